// File: rtl/dmem_lsu_pkg.sv
// dmem_lsu shared types: FSM states, RV32I load/store funct3 codes,
// access-size codes, default memory window and a byte-count helper.
package dmem_lsu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_RESP
  } lsu_state_e;

  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;
  localparam logic [2:0] F3_SB  = 3'd0;
  localparam logic [2:0] F3_SH  = 3'd1;
  localparam logic [2:0] F3_SW  = 3'd2;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  localparam logic [31:0] DMEM_BASE_DEF  = 32'h0100_0000;
  localparam logic [31:0] DMEM_BYTES_DEF = 32'h0010_0000;

  function automatic logic [2:0] size_bytes(
    input logic [1:0] s
  );
    case (s)
      SIZE_BYTE: return 3'd1;
      SIZE_HALF: return 3'd2;
      default:   return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/dmem_lsu_if.sv
// MEM-stage <-> LSU handshake: req_* (valid/ready), resp_* pulse, stall.
// master = MEM stage, slave = LSU.
interface dmem_lsu_if;

  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  req_funct3;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_fault;
  logic        stall;

  modport master (
    output req_valid, req_write, req_addr,
    output req_wdata, req_funct3,
    input  req_ready, resp_valid, resp_rdata,
    input  resp_fault, stall
  );

  modport slave (
    input  req_valid, req_write, req_addr,
    input  req_wdata, req_funct3,
    output req_ready, resp_valid, resp_rdata,
    output resp_fault, stall
  );

endinterface

// File: rtl/dmem_lsu_load_ext.sv
// lsu_load_ext: masks bytes above the access size, then sign/zero extends.
// Ports: i_data raw word, i_size SIZE_*, i_signed, o_data extended result.
module lsu_load_ext
  import dmem_lsu_pkg::*;
(
  input  logic [31:0] i_data,
  input  logic [1:0]  i_size,
  input  logic        i_signed,
  output logic [31:0] o_data
);

  logic w_sb;
  logic w_sh;

  assign w_sb = i_signed & i_data[7];
  assign w_sh = i_signed & i_data[15];

  always_comb begin
    o_data = i_data;
    case (i_size)
      SIZE_BYTE: o_data = {{24{w_sb}}, i_data[7:0]};
      SIZE_HALF: o_data = {{16{w_sh}}, i_data[15:0]};
      default:   o_data = i_data;
    endcase
  end

endmodule

// File: rtl/dmem_lsu.sv
// dmem_lsu: MEM-stage load/store unit; clock/reset, lsu (slave handshake),
// dmem_* memory port. DMEM_LSU_MISALIGN_EN splits misaligned half/word.
module dmem_lsu
  import dmem_lsu_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = DMEM_BASE_DEF,
  parameter logic [31:0] MEM_BYTES = DMEM_BYTES_DEF
) (
  input  logic        clock,
  input  logic        reset,
  dmem_lsu_if.slave   lsu,
  output logic [31:0] dmem_address,
  output logic        dmem_read_write,
  output logic [31:0] dmem_data_in,
  output logic [1:0]  dmem_access_size,
  input  logic [31:0] dmem_data_out
);

  lsu_state_e  r_state;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic        r_write;
  logic [1:0]  r_size;
  logic        r_signed;
  logic        r_split;
  logic [1:0]  r_cnt;
  logic [1:0]  r_nlast;
  logic [31:0] r_buf;
  logic        r_valid;
  logic        r_fault;
  logic [31:0] r_rdata;
  logic [31:0] r_dmem_addr;
  logic        r_dmem_rw;
  logic [31:0] r_dmem_din;
  logic [1:0]  r_dmem_size;

  logic [2:0]  w_f3;
  logic        w_f3_ok;
  logic [1:0]  w_size;
  logic [2:0]  w_nbytes;
  logic [32:0] w_end;
  logic [32:0] w_lim;
  logic        w_range_ok;
  logic        w_misal;
  logic        w_split;
  logic        w_fault;
  logic [1:0]  w_nlast;
  logic [1:0]  w_cnt_nx;
  logic [7:0]  w_byte_nx;
  logic [31:0] w_buf_nx;
  logic        w_last;
  logic [31:0] w_ext;

  assign w_f3   = lsu.req_funct3;
  assign w_size = w_f3[1:0];

  always_comb begin
    w_f3_ok = 1'b0;
    unique case (1'b1)
      lsu.req_write:
        w_f3_ok = w_f3 inside {F3_SB, F3_SH, F3_SW};
      !lsu.req_write:
        w_f3_ok = w_f3 inside {F3_LB, F3_LH, F3_LW,
                               F3_LBU, F3_LHU};
    endcase
  end

  // 33-bit sums so the top of the window cannot wrap.
  assign w_nbytes = size_bytes(w_size);
  assign w_end = {1'b0, lsu.req_addr}
               + {30'd0, w_nbytes};
  assign w_lim = {1'b0, BASE_ADDR}
               + {1'b0, MEM_BYTES};
  assign w_range_ok = (lsu.req_addr >= BASE_ADDR)
                   && (w_end <= w_lim);

  assign w_misal =
    ((w_size == SIZE_HALF) && lsu.req_addr[0]) ||
    ((w_size == SIZE_WORD) &&
     (lsu.req_addr[1:0] != 2'd0));

`ifdef DMEM_LSU_MISALIGN_EN
  assign w_split = w_misal;
`else
  assign w_split = 1'b0;
`endif

  assign w_fault = !w_f3_ok || !w_range_ok
                || (w_misal && !w_split);

  assign w_nlast = w_split ? 2'(w_nbytes - 3'd1)
                           : 2'd0;

  assign w_cnt_nx  = r_cnt + 2'd1;
  assign w_byte_nx = r_wdata[{w_cnt_nx, 3'b000} +: 8];
  assign w_last    = (r_cnt == r_nlast);

  // Split loads gather one byte per ACCESS cycle.
  assign w_buf_nx = r_split
    ? (r_buf | ({24'd0, dmem_data_out[7:0]}
                << {r_cnt, 3'b000}))
    : dmem_data_out;

  lsu_load_ext u_ext (
    .i_data   (w_buf_nx),
    .i_size   (r_size),
    .i_signed (r_signed),
    .o_data   (w_ext)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_write     <= 1'b0;
      r_size      <= SIZE_BYTE;
      r_signed    <= 1'b0;
      r_split     <= 1'b0;
      r_cnt       <= 2'd0;
      r_nlast     <= 2'd0;
      r_buf       <= '0;
      r_valid     <= 1'b0;
      r_fault     <= 1'b0;
      r_rdata     <= '0;
      r_dmem_addr <= BASE_ADDR;
      r_dmem_rw   <= 1'b0;
      r_dmem_din  <= '0;
      r_dmem_size <= SIZE_BYTE;
    end else begin
      r_valid <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (lsu.req_valid) begin
            r_addr   <= lsu.req_addr;
            r_wdata  <= lsu.req_wdata;
            r_write  <= lsu.req_write;
            r_size   <= w_size;
            r_signed <= !w_f3[2];
            r_split  <= w_split;
            r_nlast  <= w_nlast;
            r_cnt    <= 2'd0;
            r_buf    <= '0;
            if (w_fault) begin
              r_state <= ST_RESP;
              r_valid <= 1'b1;
              r_fault <= 1'b1;
              r_rdata <= '0;
            end else begin
              r_state     <= ST_ACCESS;
              r_dmem_addr <= lsu.req_addr;
              r_dmem_rw   <= lsu.req_write;
              r_dmem_size <= w_split ? SIZE_BYTE
                                     : w_size;
              r_dmem_din  <= w_split
                ? {24'd0, lsu.req_wdata[7:0]}
                : lsu.req_wdata;
            end
          end
        end
        ST_ACCESS: begin
          r_buf <= w_buf_nx;
          if (w_last) begin
            r_state     <= ST_RESP;
            r_valid     <= 1'b1;
            r_fault     <= 1'b0;
            r_rdata     <= r_write ? '0 : w_ext;
            r_dmem_addr <= BASE_ADDR;
            r_dmem_rw   <= 1'b0;
            r_dmem_din  <= '0;
            r_dmem_size <= SIZE_BYTE;
          end else begin
            r_cnt       <= w_cnt_nx;
            r_dmem_addr <= r_addr + {30'd0, w_cnt_nx};
            r_dmem_din  <= {24'd0, w_byte_nx};
          end
        end
        ST_RESP: begin
          r_state <= ST_IDLE;
          r_fault <= 1'b0;
          r_rdata <= '0;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign lsu.req_ready  = reset && (r_state == ST_IDLE);
  assign lsu.stall      =
    (r_state == ST_IDLE && lsu.req_valid && reset) ||
    (r_state == ST_ACCESS);
  assign lsu.resp_valid = r_valid;
  assign lsu.resp_rdata = r_rdata;
  assign lsu.resp_fault = r_fault;

  // A write never commits while reset is held low.
  assign dmem_read_write  = r_dmem_rw & reset;
  assign dmem_address     = r_dmem_addr;
  assign dmem_data_in     = r_dmem_din;
  assign dmem_access_size = r_dmem_size;

endmodule

// File: tb/tb_dmem_lsu.sv
// tb_dmem_lsu: directed bench for dmem_lsu with a byte-array reference
// model of the data memory and a per-cycle response checker.
module tb_dmem_lsu;
  import dmem_lsu_pkg::*;

  localparam logic [31:0] BASE = 32'h0100_0000;
  localparam logic [31:0] MEMB = 32'h0010_0000;
  localparam logic [31:0] TOP8 = BASE + MEMB - 32'd8;
`ifdef DMEM_LSU_MISALIGN_EN
  localparam bit MIS_EN = 1'b1;
`else
  localparam bit MIS_EN = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] dmem_address;
  logic        dmem_read_write;
  logic [31:0] dmem_data_in;
  logic [1:0]  dmem_access_size;
  logic [31:0] dmem_data_out;

  dmem_lsu_if lsu();

  dmem_lsu #(
    .BASE_ADDR (BASE),
    .MEM_BYTES (MEMB)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .lsu              (lsu),
    .dmem_address     (dmem_address),
    .dmem_read_write  (dmem_read_write),
    .dmem_data_in     (dmem_data_in),
    .dmem_access_size (dmem_access_size),
    .dmem_data_out    (dmem_data_out)
  );

  always #5 clock = ~clock;

  // 64 bytes at BASE plus the last 8 bytes of the window.
  logic [7:0] mem     [0:71];
  logic [7:0] ref_mem [0:71];

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int wr_cnt = 0;
  int stall_cnt = 0;
  int exp_cyc = 0;
  bit exp_active = 0;
  bit got_resp = 0;
  bit allow_wr = 0;
  bit now_resp;
  string cur_nm = "";
  logic [31:0] e_rdata;
  bit e_fault;
  int e_lat;
  int e_nwr;
  logic [31:0] last_rdata;

  function automatic int idx(input logic [31:0] a);
    if (a >= TOP8)
      return 64 + int'((a - TOP8) & 32'd7);
    return int'(a[5:0]);
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h",
               nm, got, exp);
    end
  endtask

  always @(posedge clock) cyc <= cyc + 1;

  // Data memory: combinational read, write on the edge.
  always_comb begin
    dmem_data_out = '0;
    for (int b = 0; b < 4; b++)
      dmem_data_out[8*b +: 8] =
        mem[idx(dmem_address + 32'(b))];
  end

  always @(posedge clock) begin
    if (dmem_read_write) begin
      wr_cnt++;
      for (int b = 0; b < 4; b++)
        if (b < (1 << dmem_access_size))
          mem[idx(dmem_address + 32'(b))] =
            dmem_data_in[8*b +: 8];
    end
  end

  // Reference behaviour of one request.
  task automatic model(input bit wr,
                       input logic [2:0] f3,
                       input logic [31:0] a,
                       input logic [31:0] wd);
    int n;
    bit legal;
    bit mis;
    longint endb;
    logic [31:0] v;
    n = (f3[1:0] == 2'd0) ? 1 :
        (f3[1:0] == 2'd1) ? 2 : 4;
    legal = wr ? (f3 <= 3'd2)
               : (f3 inside {3'd0, 3'd1, 3'd2,
                             3'd4, 3'd5});
    endb = longint'(a) + longint'(n);
    mis = (a % n) != 0;
    e_fault = !legal || (a < BASE) ||
              (endb > longint'(BASE) + longint'(MEMB)) ||
              (mis && !MIS_EN);
    e_rdata = '0;
    e_lat = 1;
    e_nwr = 0;
    if (!e_fault) begin
      e_lat = mis ? n + 1 : 2;
      if (wr) begin
        e_nwr = mis ? n : 1;
        for (int i = 0; i < n; i++)
          ref_mem[idx(a + 32'(i))] = wd[8*i +: 8];
      end else begin
        v = '0;
        for (int i = 0; i < n; i++)
          v[8*i +: 8] = ref_mem[idx(a + 32'(i))];
        if (!f3[2] && n < 4 && v[8*n-1])
          for (int b = 8*n; b < 32; b++) v[b] = 1'b1;
        e_rdata = v;
      end
    end
  endtask

  task automatic do_req(input string nm,
                        input bit wr,
                        input logic [2:0] f3,
                        input logic [31:0] a,
                        input logic [31:0] wd);
    @(posedge clock); #1;
    chk({nm, "_ready"}, 32'(lsu.req_ready), 32'd1);
    model(wr, f3, a, wd);
    allow_wr = (e_nwr > 0);
    wr_cnt = 0;
    stall_cnt = 0;
    got_resp = 0;
    cur_nm = nm;
    lsu.req_valid  = 1'b1;
    lsu.req_write  = wr;
    lsu.req_funct3 = f3;
    lsu.req_addr   = a;
    lsu.req_wdata  = wd;
    @(posedge clock); #1;
    lsu.req_valid = 1'b0;
    // Cycle 1 of the latency starts at the accept edge.
    exp_cyc = cyc + e_lat - 1;
    exp_active = 1'b1;
    for (int i = 0; i < 20 && !got_resp; i++)
      @(posedge clock);
    if (!got_resp) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s_timeout: got none expected resp",
               nm);
      exp_active = 1'b0;
    end
    allow_wr = 1'b0;
  endtask

  always @(negedge clock) begin
    if (lsu.stall) stall_cnt++;
    now_resp = exp_active && (cyc == exp_cyc);
    chk("resp_valid", 32'(lsu.resp_valid),
        32'(now_resp));
    if (!allow_wr)
      chk("dmem_rw_idle", 32'(dmem_read_write), 32'd0);
    if (now_resp) begin
      chk({cur_nm, "_rdata"}, lsu.resp_rdata, e_rdata);
      chk({cur_nm, "_fault"}, 32'(lsu.resp_fault),
          32'(e_fault));
      chk({cur_nm, "_writes"}, 32'(wr_cnt), 32'(e_nwr));
      chk({cur_nm, "_stall"}, 32'(stall_cnt),
          32'(e_lat));
      last_rdata = lsu.resp_rdata;
      got_resp = 1'b1;
      exp_active = 1'b0;
    end
  end

  initial begin
    for (int i = 0; i < 72; i++) begin
      mem[i] = 8'h00;
      ref_mem[i] = 8'h00;
    end
    mem[0] = 8'h11; mem[1] = 8'h22;
    mem[2] = 8'h33; mem[3] = 8'h44;
    mem[16] = 8'hEF; mem[17] = 8'hBE;
    mem[18] = 8'hAD; mem[19] = 8'hDE;
    for (int i = 0; i < 72; i++) ref_mem[i] = mem[i];
    lsu.req_valid  = 1'b0;
    lsu.req_write  = 1'b0;
    lsu.req_funct3 = 3'd0;
    lsu.req_addr   = '0;
    lsu.req_wdata  = '0;

    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst_resp_valid", 32'(lsu.resp_valid), 32'd0);
    chk("rst_rdata", lsu.resp_rdata, 32'd0);
    chk("rst_fault", 32'(lsu.resp_fault), 32'd0);
    chk("rst_stall", 32'(lsu.stall), 32'd0);
    chk("rst_ready", 32'(lsu.req_ready), 32'd0);
    chk("rst_addr", dmem_address, BASE);
    chk("rst_rw", 32'(dmem_read_write), 32'd0);
    chk("rst_din", dmem_data_in, 32'd0);
    chk("rst_size", 32'(dmem_access_size), 32'd0);
    @(posedge clock); #1;
    reset = 1'b1;
    @(negedge clock);
    chk("rel_ready", 32'(lsu.req_ready), 32'd1);

    do_req("lw10", 0, F3_LW, BASE + 32'h10, '0);
    chk("lw10_lit", last_rdata, 32'hDEAD_BEEF);
    do_req("sb3", 1, F3_SB, BASE + 32'h3,
           32'h1234_5680);
    do_req("lb3", 0, F3_LB, BASE + 32'h3, '0);
    chk("lb3_lit", last_rdata, 32'hFFFF_FF80);
    do_req("lbu3", 0, F3_LBU, BASE + 32'h3, '0);
    chk("lbu3_lit", last_rdata, 32'h0000_0080);
    do_req("lw0", 0, F3_LW, BASE, '0);
    chk("lw0_lit", last_rdata, 32'h8033_2211);

    do_req("sh20", 1, F3_SH, BASE + 32'h20,
           32'hFFFF_8001);
    do_req("lh20", 0, F3_LH, BASE + 32'h20, '0);
    chk("lh20_lit", last_rdata, 32'hFFFF_8001);
    do_req("lhu20", 0, F3_LHU, BASE + 32'h20, '0);
    chk("lhu20_lit", last_rdata, 32'h0000_8001);
    do_req("lb20", 0, F3_LB, BASE + 32'h20, '0);
    chk("lb20_lit", last_rdata, 32'h0000_0001);
    do_req("lb21", 0, F3_LB, BASE + 32'h21, '0);

    do_req("ld_f3_3", 0, 3'd3, BASE, '0);
    do_req("ld_f3_6", 0, 3'd6, BASE, '0);
    do_req("ld_f3_7", 0, 3'd7, BASE, '0);
    do_req("st_f3_3", 1, 3'd3, BASE, 32'hFFFF_FFFF);
    do_req("st_f3_4", 1, 3'd4, BASE, 32'hFFFF_FFFF);
    do_req("sw_low", 1, F3_SW, 32'h00FF_FFFC,
           32'h5555_5555);
    do_req("sw_m3", 1, F3_SW, BASE + MEMB - 32'd3,
           32'h6666_6666);
    do_req("sw_m4", 1, F3_SW, BASE + MEMB - 32'd4,
           32'hCAFE_F00D);
    do_req("lw_m4", 0, F3_LW, BASE + MEMB - 32'd4, '0);
    chk("lw_m4_lit", last_rdata, 32'hCAFE_F00D);
    do_req("lh_m2", 0, F3_LH, BASE + MEMB - 32'd2, '0);
    chk("lh_m2_lit", last_rdata, 32'hFFFF_CAFE);
    do_req("lw_m2", 0, F3_LW, BASE + MEMB - 32'd2, '0);

    do_req("sw_mis", 1, F3_SW, BASE + 32'h1,
           32'hA1B2_C3D4);
    do_req("lw_mis", 0, F3_LW, BASE + 32'h1, '0);
    do_req("lh_mis", 0, F3_LH, BASE + 32'h11, '0);
`ifdef DMEM_LSU_MISALIGN_EN
    chk("lh_mis_lit", last_rdata, 32'hFFFF_ADBE);
    do_req("lw_mis2", 0, F3_LW, BASE + 32'h1, '0);
    chk("lw_mis2_lit", last_rdata, 32'hA1B2_C3D4);

    // Reset lands on the second byte of a split store.
    @(posedge clock); #1;
    allow_wr = 1'b1;
    lsu.req_valid  = 1'b1;
    lsu.req_write  = 1'b1;
    lsu.req_funct3 = F3_SW;
    lsu.req_addr   = BASE + 32'h31;
    lsu.req_wdata  = 32'h7788_99AA;
    @(posedge clock); #1;
    lsu.req_valid = 1'b0;
    ref_mem[idx(BASE + 32'h31)] = 8'hAA;
    @(posedge clock); #1;
    reset = 1'b0;
    #1;
    chk("rstmid_rw", 32'(dmem_read_write), 32'd0);
    @(posedge clock); #1;
    chk("rstmid_ready_lo", 32'(lsu.req_ready), 32'd0);
    allow_wr = 1'b0;
    reset = 1'b1;
    @(negedge clock);
    chk("rstmid_ready", 32'(lsu.req_ready), 32'd1);
    chk("rstmid_addr", dmem_address, BASE);
`else
    do_req("sw_mis2", 1, F3_SW, BASE + 32'h31,
           32'h7788_99AA);
    @(posedge clock); #1;
    reset = 1'b0;
    @(posedge clock); #1;
    chk("rstmid_ready_lo", 32'(lsu.req_ready), 32'd0);
    reset = 1'b1;
    @(negedge clock);
    chk("rstmid_ready", 32'(lsu.req_ready), 32'd1);
`endif
    repeat (5) @(posedge clock);
    do_req("lw30", 0, F3_LW, BASE + 32'h30, '0);

    for (int i = 0; i < 72; i++)
      chk($sformatf("mem_byte%0d", i),
          32'(mem[i]), 32'(ref_mem[i]));

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
